// File: rtl/popcount31_seq_ctrl.sv
// Sequential popcount controller: feeds an operand through a shared popcount31 unit one 31-bit chunk per cycle.
// Optional threshold/fire output enabled by defining POPCOUNT_THRESH_EN.
module popcount31_seq_ctrl #(
    parameter int NCHUNK = 4,
    parameter int ACCW   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31*NCHUNK-1:0]  in_data,
    input  logic [ACCW-1:0]       in_thresh,
    output logic [30:0]           pc_operand,
    input  logic [4:0]            pc_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACCW-1:0]       out_sum,
    output logic                  out_fire
);

    localparam int CW = $clog2(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [ACCW-1:0]      acc;
    logic [31*NCHUNK-1:0] operand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand <= in_data;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Wraps modulo 2^ACCW; ACCW is sized so an all-31 approximate unit cannot overflow.
                    acc <= acc + {{(ACCW-5){1'b0}}, pc_result};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;

    // Gate the shared unit's input to zero outside RUN so it stays quiet while idle.
    assign pc_operand = (state == RUN) ? operand[31*cnt +: 31] : 31'd0;

`ifdef POPCOUNT_THRESH_EN
    logic [ACCW-1:0] thresh;

    always_ff @(posedge clk) begin
        if (rst) begin
            thresh <= '0;
        end else if (state == IDLE && in_valid) begin
            thresh <= in_thresh;
        end
    end

    assign out_fire = (state == DONE) && (acc >= thresh);
`else
    logic unused_thresh;
    assign unused_thresh = ^in_thresh;
    assign out_fire      = 1'b0;
`endif

endmodule

// File: tb/tb_popcount31_seq_ctrl.sv
// Scoreboard bench for popcount31_seq_ctrl with an exact or all-31 approximate popcount model.
module tb_popcount31_seq_ctrl;

    localparam int NCHUNK = 4;
    localparam int ACCW   = 8;
    localparam int DW     = 31 * NCHUNK;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [ACCW-1:0] in_thresh;
    logic [30:0]     pc_operand;
    logic [4:0]      pc_result;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_sum;
    logic            out_fire;

    logic approx = 1'b0;

    popcount31_seq_ctrl #(.NCHUNK(NCHUNK), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_thresh(in_thresh),
        .pc_operand(pc_operand), .pc_result(pc_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_fire(out_fire)
    );

    assign pc_result = approx ? 5'd31 : 5'($countones(pc_operand));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [ACCW-1:0] model_sum(input logic [DW-1:0] d, input logic apx);
        int s = 0;
        for (int k = 0; k < NCHUNK; k++) begin
            logic [30:0] ch;
            ch = d[31*k +: 31];
            s += apx ? 31 : $countones(ch);
        end
        return ACCW'(s);
    endfunction

    typedef struct {
        logic [ACCW-1:0] sum;
        logic            fire;
        int              acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   acc_edges[$];

    logic            started   = 1'b0;
    logic            hold_prev = 1'b0;
    logic            ov_prev   = 1'b0;
    logic            rst_prev  = 1'b1;
    logic [ACCW-1:0] sum_prev  = '0;

    // Monitor: scoreboard push on accept, pop on result handshake, plus protocol invariants.
    always @(negedge clk) begin
        if (started) begin
            exp_t e;
            exp_t got;
            check("excl", {31'b0, in_ready & out_valid}, 32'd0);
            if (!out_valid) check("fire_idle", {31'b0, out_fire}, 32'd0);
            if (hold_prev && !rst_prev) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_sum", 32'(out_sum), 32'(sum_prev));
            end
            if (rst) begin
                sb.delete();
            end else begin
                if (in_valid && in_ready) begin
                    e.sum = model_sum(in_data, approx);
`ifdef POPCOUNT_THRESH_EN
                    e.fire = (e.sum >= in_thresh);
`else
                    e.fire = 1'b0;
`endif
                    e.acc_cyc = cyc + 1;
                    sb.push_back(e);
                    acc_edges.push_back(cyc + 1);
                end
                if (out_valid && !ov_prev && sb.size() > 0)
                    check("latency", 32'(cyc - sb[0].acc_cyc), 32'(NCHUNK));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("orphan_result", 32'd1, 32'd0);
                    end else begin
                        got = sb.pop_front();
                        check("out_sum", 32'(out_sum), 32'(got.sum));
                        check("out_fire", {31'b0, out_fire}, {31'b0, got.fire});
                    end
                end
            end
        end
        hold_prev = out_valid && !out_ready;
        sum_prev  = out_sum;
        ov_prev   = out_valid;
        rst_prev  = rst;
    end

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [ACCW-1:0] th);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_thresh = th;
        wait_accept();
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_data   = DW'({$urandom, $urandom, $urandom, $urandom});
        in_thresh = ACCW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] d_steps;
    logic [DW-1:0] d_five;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_thresh = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_fire", {31'b0, out_fire}, 32'd0);
        check("rst_pc_operand", 32'(pc_operand), 32'd0);
        @(posedge clk); #1;
        rst     = 1'b0;
        started = 1'b1;

        // All ones: 4 x 31
        send({DW{1'b1}}, 8'd0);
        drain();
        @(negedge clk);
        check("idle_after_all_ones", {31'b0, in_ready}, 32'd1);

        // Chunk k carries k+1 low bits set; consumer stalls for 5 cycles
        d_steps = {31'd15, 31'd7, 31'd3, 31'd1};
        out_ready = 1'b0;
        send(d_steps, 8'd10);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0);
            in_data  = {DW{1'b1}};
            @(negedge clk);
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_sum", 32'(out_sum), 32'd10);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Same data, threshold one above the sum
        send(d_steps, 8'd11);
        drain();

        // Approximate unit returns 31 per chunk regardless of input
        approx = 1'b1;
        send(DW'({$urandom, $urandom, $urandom, $urandom}), 8'd124);
        drain();
        approx = 1'b0;

        // Abort in the second RUN cycle, then a clean 5-bit operand
        send({DW{1'b1}}, 8'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_pc_operand", 32'(pc_operand), 32'd0);
        rst = 1'b0;
        d_five = DW'(124'h1F) << 40;
        send(d_five, 8'd5);
        drain();

        // Back-to-back with in_valid held high
        acc_edges.delete();
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = {DW{1'b1}};
        in_thresh = 8'd200;
        wait_accept();
        @(posedge clk); #1;
        in_data   = DW'(124'h7) << 62;
        in_thresh = 8'd2;
        wait_accept();
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check("b2b_accepts", 32'(acc_edges.size()), 32'd2);
        if (acc_edges.size() >= 2)
            check("b2b_spacing", 32'(acc_edges[1] - acc_edges[0]), 32'(NCHUNK + 2));

        // Random operands
        for (int i = 0; i < 8; i++) begin
            send(DW'({$urandom, $urandom, $urandom, $urandom}), ACCW'($urandom_range(40, 90)));
        end
        drain();

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/popcount31_seq_ctrl.md
POPCOUNT31_SEQ_CTRL -- requirements
Module: popcount31_seq_ctrl

Interface
REQ-001 Parameter NCHUNK, default 4: number of 31-bit chunks per operand; legal range 2..8.
REQ-002 Parameter ACCW, default 8: accumulator width; SHALL be at least ceil(log2(31*NCHUNK+1)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operand offered.
REQ-006 in_ready  output  1  controller can accept an operand.
REQ-007 in_data  input  31*NCHUNK  operand; chunk k = in_data[31k+30:31k].
REQ-008 in_thresh  input  ACCW  firing threshold, sampled on accept.
REQ-009 pc_operand  output  31  drive to the shared combinational popcount31 unit.
REQ-010 pc_result  input  5  popcount31 result for pc_operand, same cycle; exact or approximate.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_sum  output  ACCW  accumulated popcount.
REQ-014 out_fire  output  1  neuron fire flag.

Function
REQ-015 FSM states: IDLE, RUN, DONE; a state encoding outside these SHALL return to IDLE on the next edge.
REQ-016 IDLE: in_ready=1. When in_valid=1, capture in_data and in_thresh, clear accumulator, set chunk counter to 0, go to RUN.
REQ-017 RUN: in_ready=0; pc_operand = chunk[counter]; each cycle acc <= acc + zero-extended pc_result; counter increments.
REQ-018 RUN SHALL last exactly NCHUNK cycles; on the cycle with counter=NCHUNK-1 the FSM goes to DONE.
REQ-019 DONE: out_valid=1; out_sum and out_fire held stable until out_ready=1, then go to IDLE.
REQ-020 Latency: accept edge T leads to out_valid high from edge T+NCHUNK. Throughput: one operand per NCHUNK+2 cycles with out_ready tied high.
REQ-021 pc_operand SHALL be all-zero outside RUN, so the shared unit does not toggle while idle.
REQ-022 Accumulation SHALL wrap modulo 2^ACCW with no saturation. An approximate unit can return up to 31 per chunk regardless of the input, and ACCW per REQ-002 covers that maximum.
REQ-023 in_valid is ignored outside IDLE; in_data and in_thresh changes after the accept edge SHALL NOT affect the current result.
REQ-024 out_valid SHALL NOT fall without an out_ready handshake; out_ready outside DONE is ignored.
REQ-025 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-026 When rst=1 at an edge: state=IDLE, counter=0, acc=0, captured operand=0, captured threshold=0.
REQ-027 Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_fire=0, pc_operand=0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation; no out_valid is produced for the aborted operand.

Configuration
REQ-029 Macro POPCOUNT_THRESH_EN.
- Defined: the threshold register is present and out_fire = (out_sum >= captured threshold), unsigned; it is valid only while out_valid=1 and is 0 otherwise.
- Undefined: no threshold register, in_thresh is unused, and out_fire is constant 0.

Verification
REQ-030 Bench models the popcount unit as exact unless stated. NCHUNK=4, in_data all ones, out_ready=1 -> out_valid at T+4 with out_sum=124; then in_ready=1 again.
REQ-031 in_data chunk k has k+1 LSBs set (1,2,3,4), with out_ready held low for 5 cycles -> out_sum=10 held stable and out_valid=1 throughout; in_valid pulses during that window are not accepted.
REQ-032 Approximate model returning 31 for every chunk -> out_sum=124, with no wrap at ACCW=8.
REQ-033 With POPCOUNT_THRESH_EN: in_thresh=10 and a sum of 10 -> out_fire=1; in_thresh=11 with the same data -> out_fire=0. Without the macro -> out_fire=0 in both cases.
REQ-034 rst asserted on the second RUN cycle -> next cycle in_ready=1, out_valid=0, pc_operand=0; a following operand with 5 bits set yields out_sum=5 with no residue from the aborted one.
REQ-035 Two back-to-back operands with in_valid held high and out_ready=1 -> accept edges exactly NCHUNK+2 cycles apart, and the results come out in order.
